// File: rtl/stf_capture_fifo.sv
// stf_capture_fifo: captures CH x W sample frames from a slow clock domain.
// slowclk is sampled as data through a synchroniser; each qualified rising
// edge writes the current frame into a small show-ahead FIFO. The fast-side
// consumer drains it with valid/ready. Frames arriving while the FIFO is full
// and not being popped are dropped, counted (saturating) and flagged.
module stf_capture_fifo #(
    parameter int W           = 16,
    parameter int CH          = 2,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         slowclk,
    input  logic [CH*W-1:0]              data,
    input  logic                         en,
    output logic [CH*W-1:0]              out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         ovf,
    output logic [7:0]                   drops,
    input  logic                         ovf_clr
);

    localparam int FW = CH * W;
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    // Synchroniser chain and a parallel "sample valid" chain. The zeros loaded
    // into the chain at reset are not real samples of slowclk, so arming waits
    // until a genuine low has travelled all the way through.
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_vld_q;
    logic                   s;
    logic                   p_q;
    logic                   armed_q;
    logic                   cap_edge;

    // FIFO state
    logic [FW-1:0]          mem [DEPTH];
    logic [PW-1:0]          wr_ptr_q;
    logic [PW-1:0]          rd_ptr_q;
    logic [LW-1:0]          level_q;
    logic                   full;
    logic                   push;
    logic                   pop;
    logic                   drop;

    assign s        = sync_q[SYNC_STAGES-1];
    assign cap_edge = s & ~p_q & armed_q & en;

    // Shift slowclk through the synchroniser; keep the delayed copy and arm flag.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            sync_vld_q <= '0;
            p_q        <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], slowclk};
            sync_vld_q <= {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
            p_q        <= s;
            if (sync_vld_q[SYNC_STAGES-1] && !s) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign full      = (level_q == LW'(DEPTH));
    assign out_valid = (level_q != '0);
    assign level     = level_q;

    // Decode push/pop/drop; a full FIFO still accepts a capture if it pops too.
    // NOTE: every signal driven here gets a default first, so no path can leave
    // it unassigned and infer a latch.
    always_comb begin
        pop  = 1'b0;
        push = 1'b0;
        drop = 1'b0;
        pop  = out_valid & out_ready;
        if (cap_edge) begin
            if (!full || pop) begin
                push = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end
    end

    // Frame storage write port.
    // NOTE: the storage array has no reset; only pointers and level need one,
    // and the empty-state output is forced to zero below instead.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is 2**PW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Show-ahead head; reads zero while empty so reset leaves out_data at 0.
    always_comb begin
        out_data = '0;
        if (out_valid) begin
            out_data = mem[rd_ptr_q];
        end
    end

    // Sticky overflow flag and saturating drop counter; a clear beats a drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf   <= 1'b0;
            drops <= 8'd0;
        end else if (ovf_clr) begin
            ovf   <= 1'b0;
            drops <= 8'd0;
        end else if (drop) begin
            ovf <= 1'b1;
            if (drops != 8'hFF) begin
                drops <= drops + 8'd1;
            end
        end
    end

endmodule
